serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal values are at least 1.
REQ-002 Parameter BITS_PER_CYCLE, default 1: bits processed per clock; legal values are 1..WIDTH and SHALL divide WIDTH exactly.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  request a subtraction; accepted only in IDLE.
REQ-006 a  input  WIDTH  minuend; sampled on the accepting edge.
REQ-007 b  input  WIDTH  subtrahend; sampled on the accepting edge.
REQ-008 bin  input  1  borrow-in to bit 0; sampled on the accepting edge.
REQ-009 busy  output  1  high while the state is RUN.
REQ-010 done  output  1  one-cycle pulse; diff, bout and ovf are valid.
REQ-011 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  borrow-out from the MSB.
REQ-013 ovf  output  1  two's-complement signed overflow of a - b - bin.

Function
REQ-014 States: IDLE, RUN and DONE. Let N = WIDTH/BITS_PER_CYCLE.
REQ-015 IDLE with start=1 at a clock edge: capture a, b and bin; clear the step counter; move to RUN.
REQ-016 IDLE with start=0: stay in IDLE; all outputs hold their current values.
REQ-017 RUN: each edge processes the next BITS_PER_CYCLE bits, LSB chunk first, through a rippled borrow chain.
- Chunk borrow-in is the registered borrow from the previous chunk; the first chunk uses the captured bin.
- Results are shifted into the diff register.
REQ-018 After exactly N RUN edges, move to DONE; done is visible N cycles after the accepting edge.
REQ-019 DONE: done=1 for exactly one cycle, then move to IDLE unconditionally.
REQ-020 Per-bit function: d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
REQ-021 ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-022 diff, bout and ovf SHALL change only while busy=1, and SHALL hold their final values until the next accepted start.
- During RUN, diff holds partial results; consumers SHALL use diff only when done=1 or when idle.
REQ-023 start in RUN or DONE SHALL be ignored (not queued); operand changes after the accepting edge SHALL have no effect.
REQ-024 WIDTH=BITS_PER_CYCLE: N=1; operation is RUN for one edge, then DONE.

Reset
REQ-025 rst_n=0 at an edge forces IDLE, step counter=0, busy=0, done=0, diff=0, bout=0, ovf=0, from any state.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation; no done pulse follows.
REQ-027 start sampled on the same edge as rst_n=0 SHALL be ignored.

Structure
REQ-028 Shared package serial_sub_pkg SHALL hold the state enum (IDLE, RUN, DONE).
REQ-029 The single-bit borrow cell SHALL be a sub-module fs_cell (x, y, bi -> d, bo).
- BITS_PER_CYCLE instances of fs_cell SHALL be chained per step.
REQ-030 The step counter width SHALL be $clog2(N+1).
REQ-031 No combinational path from inputs to outputs.

Verification
REQ-032 WIDTH=8, BPC=1: a=0x05, b=0x03, bin=0, start pulse -> busy high for 8 cycles; done at cycle 8; diff=0x02, bout=0, ovf=0.
REQ-033 WIDTH=8, BPC=1: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
REQ-034 WIDTH=8, BPC=4: a=0x10, b=0x0F, bin=1 -> done 2 cycles after the accepting edge; diff=0x00, bout=0.
REQ-035 WIDTH=1, BPC=1: all 8 (a, b, bin) combinations -> (diff, bout) = 00, 11, 11, 01, 10, 00, 00, 11 in order 000..111.
REQ-036 WIDTH=8: rst_n=0 at RUN step 3 -> next cycle all outputs 0 and IDLE; no done pulse; a new start then completes normally.
REQ-037 WIDTH=8: start re-asserted with new operands during RUN -> ignored; result equals the first operands only; done pulses once.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding for the serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fs_cell.sv
// fs_cell: single-bit full subtractor cell of the borrow chain
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, BITS_PER_CYCLE bits per clock, LSB chunk first
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic r_brw, r_a_msb, r_b_msb, r_bout, r_ovf;
  logic [BITS_PER_CYCLE:0] w_brw;
  logic [BITS_PER_CYCLE-1:0] w_d;
  logic [WIDTH+BITS_PER_CYCLE-1:0] w_cat;
  logic w_last, w_accept;
  assign w_brw[0] = r_brw;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
    fs_cell u_cell (
      .x (r_a[i]),
      .y (r_b[i]),
      .bi(w_brw[i]),
      .d (w_d[i]),
      .bo(w_brw[i+1])
    );
  end
  // new chunk enters at the top so the LSB chunk ends up at bit 0 after N steps
  assign w_cat    = {w_d, r_diff};
  assign w_last   = r_cnt == CW'(N - 1);
  assign w_accept = (r_state == IDLE) && start;
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_brw   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= a;
      r_b     <= b;
      r_brw   <= bin;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == RUN) begin
      r_cnt  <= r_cnt + 1'b1;
      r_a    <= r_a >> BITS_PER_CYCLE;
      r_b    <= r_b >> BITS_PER_CYCLE;
      r_brw  <= w_brw[BITS_PER_CYCLE];
      r_diff <= w_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
      r_bout <= w_brw[BITS_PER_CYCLE];
      r_ovf  <= (r_a_msb != r_b_msb) && (w_d[BITS_PER_CYCLE-1] != r_a_msb);
    end
  end
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed checks of three configurations against an arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  logic st[3];
  logic bi[3];
  logic busy[3], done[3], bo[3], ov[3];
  logic [7:0] a0, b0, a1, b1, d0, d1;
  logic a2, b2, d2;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_s81 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(a0), .b(b0), .bin(bi[0]),
    .busy(busy[0]), .done(done[0]), .diff(d0), .bout(bo[0]), .ovf(ov[0]));
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_s84 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(a1), .b(b1), .bin(bi[1]),
    .busy(busy[1]), .done(done[1]), .diff(d1), .bout(bo[1]), .ovf(ov[1]));
  serial_subtractor #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_s11 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(a2), .b(b2), .bin(bi[2]),
    .busy(busy[2]), .done(done[2]), .diff(d2), .bout(bo[2]), .ovf(ov[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input int k, input logic s, input logic [7:0] av, input logic [7:0] bv, input logic bin_v);
    st[k] = s;
    bi[k] = bin_v;
    case (k)
      0: begin a0 = av; b0 = bv; end
      1: begin a1 = av; b1 = bv; end
      default: begin a2 = av[0]; b2 = bv[0]; end
    endcase
  endtask
  function automatic logic [7:0] rd_diff(input int k);
    return (k == 0) ? d0 : (k == 1) ? d1 : {7'b0, d2};
  endfunction
  task automatic model(input int w, input logic [7:0] av, input logic [7:0] bv, input logic bin_v,
                       output logic [7:0] d, output logic bout_m, output logic ovf_m);
    int m, ua, ub, r, sa, sb, s;
    m  = (1 << w) - 1;
    ua = int'(av) & m;
    ub = int'(bv) & m;
    r  = ua - ub - int'(bin_v);
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    s  = sa - sb - int'(bin_v);
    d      = 8'(r & m);
    bout_m = r < 0;
    ovf_m  = (s < -(1 << (w - 1))) || (s > (1 << (w - 1)) - 1);
  endtask
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv, input logic bin_v, input bit meddle);
    int n, w, got;
    logic [7:0] ed;
    logic eb, eo;
    n = (k == 0) ? 8 : (k == 1) ? 2 : 1;
    w = (k == 2) ? 1 : 8;
    model(w, av, bv, bin_v, ed, eb, eo);
    @(negedge clk);
    drive(k, 1'b1, av, bv, bin_v);
    @(posedge clk);
    #1;
    drive(k, meddle, 8'($urandom), 8'($urandom), 1'($urandom));
    chk("busy_acc", busy[k], 1);
    got = 0;
    for (int c = 1; c <= n + 3 && got == 0; c++) begin
      @(posedge clk);
      #1;
      if (done[k]) got = c;
      if (meddle) drive(k, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    drive(k, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    chk("latency", got, n);
    chk("diff", rd_diff(k), ed);
    chk("bout", bo[k], eb);
    if (w > 1) chk("ovf", ov[k], eo);
    chk("busy_done", busy[k], 0);
    @(posedge clk);
    #1;
    chk("done_pulse", done[k], 0);
    chk("diff_hold", rd_diff(k), ed);
    chk("bout_hold", bo[k], eb);
  endtask
  initial begin
    logic [1:0] tab [8];
    int seen;
    tab = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
      chk("rst_diff", rd_diff(k), 0);
      chk("rst_bout", bo[k], 0);
      chk("rst_ovf", ov[k], 0);
    end
    rst_n = 1'b1;
    run_op(0, 8'h05, 8'h03, 1'b0, 0);
    run_op(0, 8'h00, 8'h01, 1'b0, 0);
    run_op(0, 8'h80, 8'h01, 1'b0, 0);
    chk("ovf_80m01", ov[0], 1);
    run_op(1, 8'h10, 8'h0F, 1'b1, 0);
    for (int i = 0; i < 8; i++) begin
      run_op(2, 8'(i >> 2), 8'(i >> 1), 1'(i), 0);
      chk("w1_table", {d2, bo[2]}, tab[i]);
    end
    run_op(0, 8'h3C, 8'hA5, 1'b1, 1);
    for (int i = 0; i < 30; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    run_op(1, 8'h7F, 8'hFF, 1'b1, 0);
    @(negedge clk);
    drive(0, 1'b1, 8'h9A, 8'h21, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b1, 8'h44, 8'h11, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_busy", busy[0], 0);
    chk("midrst_done", done[0], 0);
    chk("midrst_diff", d0, 0);
    chk("midrst_bout", bo[0], 0);
    chk("midrst_ovf", ov[0], 0);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done[0] || busy[0]) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    run_op(0, 8'hC8, 8'h37, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
